// File: rtl/change_dispenser.sv
// change_dispenser: pays a customer balance out as Rs.20/10/5 coins to a coin
// hopper, one coin per handshake, greedy largest-coin-first with no backtracking.
// Keeps a stock counter per denomination and reports any amount left unpaid.
//
// Handshakes:
//   request : a balance is accepted on a rising edge where req_valid & req_ready.
//             req_ready is high only while idle, and balance is sampled on that edge.
//   hopper  : coin_valid/coin_code are held stable until a rising edge with
//             coin_valid & coin_ack. That edge consumes the coin. coin_ack is
//             ignored whenever coin_valid is low.
//
// Optional feature: define CHANGE_ACK_TIMEOUT_EN to give up on a coin after
// ACK_TIMEOUT cycles without an acknowledge. The request then finishes short,
// and stock and the remaining amount are left unchanged.
module change_dispenser #(
   parameter int AMT_W       = 5,
   parameter int CNT_W       = 6,
   parameter int INIT_5      = 8,
   parameter int INIT_10     = 8,
   parameter int INIT_20     = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AMT_W-1:0] balance,
   input  logic             refill,
   output logic             coin_valid,
   output logic [1:0]       coin_code,
   input  logic             coin_ack,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   output logic             busy,
   output logic [CNT_W-1:0] cnt5,
   output logic [CNT_W-1:0] cnt10,
   output logic [CNT_W-1:0] cnt20,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_ISSUE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [AMT_W-1:0] V5  = AMT_W'(5);
   localparam logic [AMT_W-1:0] V10 = AMT_W'(10);
   localparam logic [AMT_W-1:0] V20 = AMT_W'(20);

   localparam logic [1:0] C_NONE = 2'b00;
   localparam logic [1:0] C_5    = 2'b01;
   localparam logic [1:0] C_10   = 2'b10;
   localparam logic [1:0] C_20   = 2'b11;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt5_q, cnt5_d;
   logic [CNT_W-1:0] cnt10_q, cnt10_d;
   logic [CNT_W-1:0] cnt20_q, cnt20_d;
   logic             coin_valid_q, coin_valid_d;
   logic [1:0]       coin_code_q, coin_code_d;
   logic             done_q, done_d;
   logic             short_q, short_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;

   logic             accept;
   logic             ack_hit;
   logic             tmo_hit;
   logic [1:0]       sel_code;
   logic             sel_short;
   logic [AMT_W-1:0] coin_val;

`ifdef CHANGE_ACK_TIMEOUT_EN
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   assign accept  = req_valid & (state_q == S_IDLE);
   assign ack_hit = coin_valid_q & coin_ack;

`ifdef CHANGE_ACK_TIMEOUT_EN
   assign tmo_hit = (state_q == S_ISSUE) & ~ack_hit & (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
`else
   // This build waits for the hopper forever, so the timeout can never fire.
   assign tmo_hit = (ACK_TIMEOUT < 0);
`endif

   // Greedy coin choice for the current remaining amount. Coins are all
   // multiples of 5, so the residue test gives the same answer on every visit.
   always_comb begin
      sel_code  = C_NONE;
      sel_short = 1'b0;
      if ((rem_q % V5) != '0)                  sel_short = 1'b1;
      else if (rem_q >= V20 && cnt20_q != '0) sel_code  = C_20;
      else if (rem_q >= V10 && cnt10_q != '0) sel_code  = C_10;
      else if (rem_q >= V5  && cnt5_q  != '0) sel_code  = C_5;
      else if (rem_q != '0)                    sel_short = 1'b1;
   end

   // Value of the coin currently presented to the hopper.
   always_comb begin
      case (coin_code_q)
         C_5:     coin_val = V5;
         C_10:    coin_val = V10;
         C_20:    coin_val = V20;
         default: coin_val = '0;
      endcase
   end

   // State and datapath register; reset abandons any coin in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rem_q        <= '0;
         cnt5_q       <= CNT_W'(INIT_5);
         cnt10_q      <= CNT_W'(INIT_10);
         cnt20_q      <= CNT_W'(INIT_20);
         coin_valid_q <= 1'b0;
         coin_code_q  <= C_NONE;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
         remaining_q  <= '0;
`ifdef CHANGE_ACK_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         cnt5_q       <= cnt5_d;
         cnt10_q      <= cnt10_d;
         cnt20_q      <= cnt20_d;
         coin_valid_q <= coin_valid_d;
         coin_code_q  <= coin_code_d;
         done_q       <= done_d;
         short_q      <= short_d;
         remaining_q  <= remaining_d;
`ifdef CHANGE_ACK_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_SELECT;
         S_SELECT: state_d = (sel_code != C_NONE) ? S_ISSUE : S_DONE;
         S_ISSUE: begin
            if (ack_hit)      state_d = S_SELECT;
            else if (tmo_hit) state_d = S_DONE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, remaining amount and stock.
   always_comb begin
      rem_d        = rem_q;
      cnt5_d       = cnt5_q;
      cnt10_d      = cnt10_q;
      cnt20_d      = cnt20_q;
      coin_valid_d = coin_valid_q;
      coin_code_d  = coin_code_q;
      done_d       = 1'b0;
      short_d      = short_q;
      remaining_d  = remaining_q;
`ifdef CHANGE_ACK_TIMEOUT_EN
      tmo_d        = '0;
`endif
      case (state_q)
         S_IDLE: begin
            // A refill in the accept cycle lands on the same edge, so the
            // following selection already sees the full stock.
            if (refill) begin
               cnt5_d  = CNT_W'(INIT_5);
               cnt10_d = CNT_W'(INIT_10);
               cnt20_d = CNT_W'(INIT_20);
            end
            if (accept) begin
               rem_d       = balance;
               short_d     = 1'b0;
               remaining_d = '0;
            end
         end
         S_SELECT: begin
            if (sel_code != C_NONE) begin
               coin_valid_d = 1'b1;
               coin_code_d  = sel_code;
            end else begin
               done_d      = 1'b1;
               short_d     = sel_short;
               remaining_d = rem_q;
            end
         end
         S_ISSUE: begin
`ifdef CHANGE_ACK_TIMEOUT_EN
            tmo_d = tmo_q + TMO_W'(1);
`endif
            if (ack_hit) begin
               rem_d        = rem_q - coin_val;
               coin_valid_d = 1'b0;
               coin_code_d  = C_NONE;
               case (coin_code_q)
                  C_5:     cnt5_d  = cnt5_q  - CNT_W'(1);
                  C_10:    cnt10_d = cnt10_q - CNT_W'(1);
                  C_20:    cnt20_d = cnt20_q - CNT_W'(1);
                  default: ;
               endcase
            end else if (tmo_hit) begin
               coin_valid_d = 1'b0;
               coin_code_d  = C_NONE;
               done_d       = 1'b1;
               short_d      = 1'b1;
               remaining_d  = rem_q;
            end
         end
         default: ;
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = ~req_ready;
   assign coin_valid = coin_valid_q;
   assign coin_code  = coin_code_q;
   assign done       = done_q;
   assign short      = short_q;
   assign remaining  = remaining_q;
   assign cnt5       = cnt5_q;
   assign cnt10      = cnt10_q;
   assign cnt20      = cnt20_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed balance requests, a hopper model with
// programmable acknowledge delay, and a scoreboard monitor that checks every
// accepted coin and every done report against queued expectations.
module tb_change_dispenser;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] balance;
   logic       refill;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       coin_ack;
   logic       done;
   logic       short;
   logic [4:0] remaining;
   logic       busy;
   logic [5:0] cnt5, cnt10, cnt20;
   logic [1:0] state_dbg;

   change_dispenser dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .balance    (balance),
      .refill     (refill),
      .coin_valid (coin_valid),
      .coin_code  (coin_code),
      .coin_ack   (coin_ack),
      .done       (done),
      .short      (short),
      .remaining  (remaining),
      .busy       (busy),
      .cnt5       (cnt5),
      .cnt10      (cnt10),
      .cnt20      (cnt20),
      .state_dbg  (state_dbg)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [1:0] exp_coin_q[$];
   logic [5:0] exp_done_q[$];   // {short, remaining}

   int ack_delay = 0;
   bit hopper_en = 1'b1;
   int wait_cnt  = 0;

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event not expected", name);
   endtask

   // Hopper model: acknowledges a presented coin after ack_delay cycles, one-cycle ack.
   initial begin
      coin_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (coin_ack) coin_ack = 1'b0;
         else if (coin_valid && hopper_en) begin
            if (wait_cnt >= ack_delay) begin
               coin_ack = 1'b1;
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   // Monitor / scoreboard
   initial begin
      logic       prev_valid;
      logic       prev_ack;
      logic [1:0] prev_code;
      logic [5:0] e;
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
      prev_code  = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (prev_valid && !prev_ack && coin_valid)
               check("coin_code_stable", int'(coin_code), int'(prev_code));
            if (coin_valid && coin_ack) begin
               if (exp_coin_q.size() == 0) fail_now("unexpected_coin");
               else check("coin_code", int'(coin_code), int'(exp_coin_q.pop_front()));
            end
            if (done) begin
               if (exp_done_q.size() == 0) fail_now("unexpected_done");
               else begin
                  e = exp_done_q.pop_front();
                  check("done_short", int'(short), int'(e[5]));
                  check("done_remaining", int'(remaining), int'(e[4:0]));
               end
            end
            prev_valid = coin_valid;
            prev_ack   = coin_ack;
            prev_code  = coin_code;
         end
      end
   end

   // Issue one request, waiting (bounded) for req_ready first.
   task automatic send(input logic [4:0] bal, input logic rf);
      int t;
      @(negedge clk);
      t = 0;
      while (!req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) fail_now("req_ready_timeout");
      req_valid = 1'b1;
      balance   = bal;
      refill    = rf;
      @(negedge clk);
      req_valid = 1'b0;
      refill    = 1'b0;
   endtask

   // Wait (bounded) for the done pulse; optionally require req_ready low throughout.
   task automatic wait_done(input int budget, input bit chk_ready);
      int t;
      t = 0;
      while (!done && t < budget) begin
         if (chk_ready) check("ready_low_while_busy", int'(req_ready), 0);
         @(negedge clk);
         t++;
      end
      check("done_seen", int'(done), 1);
      if (chk_ready) check("ready_low_at_done", int'(req_ready), 0);
   endtask

   task automatic wait_coin_valid(input int budget);
      int t;
      t = 0;
      while (!coin_valid && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("coin_valid_seen", int'(coin_valid), 1);
   endtask

   task automatic check_cnts(input string name, input int c5, input int c10, input int c20);
      check({name, "_cnt5"},  int'(cnt5),  c5);
      check({name, "_cnt10"}, int'(cnt10), c10);
      check({name, "_cnt20"}, int'(cnt20), c20);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      balance   = '0;
      refill    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_coin_valid", int'(coin_valid), 0);
      check("rst_coin_code",  int'(coin_code), 0);
      check("rst_done",       int'(done), 0);
      check("rst_short",      int'(short), 0);
      check("rst_remaining",  int'(remaining), 0);
      check("rst_req_ready",  int'(req_ready), 1);
      check("rst_busy",       int'(busy), 0);
      check_cnts("rst", 8, 8, 8);

      // Balance 15, ack one cycle after valid: 10 then 5
      ack_delay = 1;
      exp_coin_q.push_back(2'b10);
      exp_coin_q.push_back(2'b01);
      exp_done_q.push_back({1'b0, 5'd0});
      send(5'd15, 1'b0);
      wait_done(100, 1'b1);
      check_cnts("t1", 7, 7, 8);

      // Balance 30, ack delayed 4 cycles: 20 then 10
      ack_delay = 4;
      exp_coin_q.push_back(2'b11);
      exp_coin_q.push_back(2'b10);
      exp_done_q.push_back({1'b0, 5'd0});
      send(5'd30, 1'b0);
      wait_done(100, 1'b1);
      check_cnts("t2", 7, 6, 7);

      // Refill while idle restores every stock
      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      check_cnts("refill", 8, 8, 8);

      // Drain Rs.10 to 0 and Rs.5 to 1
      ack_delay = 0;
      for (int i = 0; i < 8; i++) begin
         exp_coin_q.push_back(2'b10);
         exp_done_q.push_back({1'b0, 5'd0});
         send(5'd10, 1'b0);
         wait_done(50, 1'b0);
      end
      for (int i = 0; i < 7; i++) begin
         exp_coin_q.push_back(2'b01);
         exp_done_q.push_back({1'b0, 5'd0});
         send(5'd5, 1'b0);
         wait_done(50, 1'b0);
      end
      check_cnts("drain", 1, 0, 8);

      // Balance 15 with only one Rs.5 left: pays 5, short by 10
      exp_coin_q.push_back(2'b01);
      exp_done_q.push_back({1'b1, 5'd10});
      send(5'd15, 1'b0);
      wait_done(50, 1'b1);
      check_cnts("t3", 0, 0, 8);

      // Balance 7: no coin, short by 7; result holds after done
      exp_done_q.push_back({1'b1, 5'd7});
      send(5'd7, 1'b0);
      wait_done(50, 1'b1);
      repeat (3) @(negedge clk);
      check("hold_short", int'(short), 1);
      check("hold_remaining", int'(remaining), 7);

      // Balance 0: done two cycles after the accept, one cycle wide
      exp_done_q.push_back({1'b0, 5'd0});
      check("zero_ready", int'(req_ready), 1);
      req_valid = 1'b1;
      balance   = 5'd0;
      @(negedge clk);
      req_valid = 1'b0;
      check("zero_done_cycle1", int'(done), 0);
      @(negedge clk);
      check("zero_done_cycle2", int'(done), 1);
      @(negedge clk);
      check("zero_done_pulse_end", int'(done), 0);
      check("zero_ready_after", int'(req_ready), 1);

      // Refill in the accept cycle: selection sees restored stock
      ack_delay = 1;
      exp_coin_q.push_back(2'b10);
      exp_coin_q.push_back(2'b01);
      exp_done_q.push_back({1'b0, 5'd0});
      send(5'd15, 1'b1);
      wait_done(100, 1'b1);
      check_cnts("refill_accept", 7, 7, 8);

      // Refill ignored mid-payout, then reset aborts the coin in flight
      hopper_en = 1'b0;
      exp_coin_q.push_back(2'b10);
      exp_done_q.push_back({1'b0, 5'd0});
      send(5'd10, 1'b0);
      wait_coin_valid(20);
      refill = 1'b1;
      repeat (2) @(negedge clk);
      refill = 1'b0;
      check("busy_refill_cnt10", int'(cnt10), 7);
      check("busy_refill_cnt5", int'(cnt5), 7);
      check("held_coin_valid", int'(coin_valid), 1);
      check("held_coin_code", int'(coin_code), 2);
      reset = 1'b1;
      #1;
      check("abort_coin_valid", int'(coin_valid), 0);
      check_cnts("abort", 8, 8, 8);
      exp_coin_q.delete();
      exp_done_q.delete();
      @(negedge clk);
      reset = 1'b0;
      hopper_en = 1'b1;
      @(negedge clk);
      check("abort_ready", int'(req_ready), 1);
      check("abort_done", int'(done), 0);

`ifdef CHANGE_ACK_TIMEOUT_EN
      // No ack: coin withdrawn after the timeout, request finishes short
      begin
         int vc;
         hopper_en = 1'b0;
         exp_done_q.push_back({1'b1, 5'd20});
         send(5'd20, 1'b0);
         wait_coin_valid(20);
         vc = 0;
         while (coin_valid && vc < 100) begin
            vc++;
            @(negedge clk);
         end
         check("timeout_valid_cycles", vc, 16);
         wait_done(10, 1'b1);
         check("timeout_cnt20", int'(cnt20), 8);
         hopper_en = 1'b1;
      end
`endif

      repeat (3) @(negedge clk);
      check("coin_q_empty", exp_coin_q.size(), 0);
      check("done_q_empty", exp_done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
